// File: rtl/r_sync.sv
// r_sync: per-packet port synchronizer for the 1x4 router.
// Captures the header address, steers the controller write strobe to one of
// four output FIFOs, returns that FIFO's full flag, drives per-port valid_out,
// and issues a one-cycle soft_reset to any port stalled for TIMEOUT cycles.
module r_sync #(
  parameter int unsigned TIMEOUT   = 30,
  parameter int unsigned CNT_WIDTH = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       detect_add,
  input  logic [1:0] data_in,
  input  logic       write_enb_reg,
  input  logic [3:0] read_enb,
  input  logic [3:0] empty,
  input  logic [3:0] full,
  output logic [3:0] write_enb,
  output logic       fifo_full,
  output logic [3:0] valid_out,
  output logic [3:0] soft_reset
);

  // Terminal count: the stalled cycle that reaches it is the TIMEOUT-th one.
  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(TIMEOUT - 1);

  logic [1:0]           addr_q, addr_d;
  logic [CNT_WIDTH-1:0] cnt_q [4];
  logic [CNT_WIDTH-1:0] cnt_d [4];
  logic [3:0]           soft_reset_q, soft_reset_d;
  logic [3:0]           stalled;

  // Port has data waiting but the output side is not draining it.
  assign stalled = ~empty & ~read_enb;

  // Next-state: address latch and per-port stall counters.
  always_comb begin
    addr_d       = detect_add ? data_in : addr_q;
    soft_reset_d = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (stalled[i]) begin
        if (cnt_q[i] == CntMax) begin
          // Restart from zero so a persisting stall cannot pulse back-to-back.
          soft_reset_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // State registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q       <= 2'b00;
      soft_reset_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      addr_q       <= addr_d;
      soft_reset_q <= soft_reset_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Outputs: zero-latency decode of the registered address; a same-cycle
  // header therefore steers with the previous address.
  always_comb begin
    write_enb  = (write_enb_reg && !reset) ? (4'b0001 << addr_q) : 4'b0000;
    fifo_full  = full[addr_q];
    valid_out  = ~empty;
    soft_reset = soft_reset_q;
  end

endmodule
